// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO edge-interrupt controller.
// Contents: register group indices, group count, words-per-group helper.
package gpio_pkg;

    // Order of the register groups inside the window; each group spans W words.
    typedef enum int unsigned {
        GRP_ENABLE  = 32'd0,
        GRP_RISE    = 32'd1,
        GRP_FALL    = 32'd2,
        GRP_PENDING = 32'd3,
        GRP_STATUS  = 32'd4
    } gpio_grp_e;

    localparam int GROUP_COUNT = 32'd5;

    // Number of bus words needed to hold one bit per pin.
    function automatic int words_for(input int num_io, input int data_width);
        return (num_io + data_width - 32'd1) / data_width;
    endfunction

endpackage

// File: rtl/arilla_bus_if.sv
// Arilla peripheral bus: single outstanding access, controller holds the
// request until ready. data_ctp = controller-to-peripheral write data,
// data_ptc = peripheral-to-controller read data, valid with ready.
interface arilla_bus_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32
);
    logic                 valid;
    logic                 write;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] data_ctp;
    logic [DataWidth-1:0] data_ptc;
    logic                 ready;

    modport peripheral (input valid, write, addr, data_ctp, output data_ptc, ready);
    modport controller (output valid, write, addr, data_ctp, input data_ptc, ready);
endinterface

// File: rtl/gpio_edge_detect.sv
// Per-pin synchronizer, history flop and edge detection.
// Ports: clk, rst (sync active-high), pins_in (async levels),
//        level (synchronized), rise/fall (one-cycle edge flags),
//        armed (high once the chain holds real samples).
module gpio_edge_detect #(
    parameter int NumIO      = 32,
    parameter int SyncStages = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [NumIO-1:0] pins_in,
    output logic [NumIO-1:0] level,
    output logic [NumIO-1:0] rise,
    output logic [NumIO-1:0] fall,
    output logic             armed
);
    // Chain plus history must all be loaded from the pins before an edge
    // means anything; otherwise a pin high at reset looks like a rising edge.
    localparam int ArmCount = SyncStages + 1;
    localparam int CntW     = $clog2(ArmCount + 1);

    logic [SyncStages-1:0][NumIO-1:0] sync_r;
    logic [NumIO-1:0]                 hist_r;
    logic [CntW-1:0]                  cnt_r;

    // Synchronizer chain, history and saturating arm counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '0;
            hist_r <= '0;
            cnt_r  <= '0;
        end else begin
            sync_r <= {sync_r[SyncStages-2:0], pins_in};
            hist_r <= sync_r[SyncStages-1];
            if (cnt_r != CntW'(ArmCount)) begin
                cnt_r <= cnt_r + CntW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    assign level = sync_r[SyncStages-1];
    assign rise  = level & ~hist_r;
    assign fall  = ~level & hist_r;
    assign armed = (cnt_r == CntW'(ArmCount));
endmodule

// File: rtl/periph_mem_interface.sv
// Bridges arilla bus accesses to a simple word-indexed register port.
// Ports: clk, rst_n (async active-low), bus (peripheral side),
//        wr_en/word_addr/wdata (write strobe + address to registers),
//        rdata (combinational register read data for word_addr).
// Every access is acknowledged one cycle after it is taken; accesses
// outside the window read 0 and write nothing.
module periph_mem_interface #(
    parameter logic [31:0] BaseAddress = 32'h0000_0000,
    parameter int          SizeWords   = 16,
    parameter int          DataWidth   = 32,
    parameter int          AddrWidth   = 32,
    parameter int          WordAddrW   = $clog2(SizeWords)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    arilla_bus_if.peripheral     bus,
    output logic                 wr_en,
    output logic [WordAddrW-1:0] word_addr,
    output logic [DataWidth-1:0] wdata,
    input  logic [DataWidth-1:0] rdata
);
    localparam int ByteShift = $clog2(DataWidth / 8);
    localparam logic [AddrWidth-1:0] Base = AddrWidth'(BaseAddress);

    logic [AddrWidth-1:0] offset_s;
    logic                 hit_s;
    logic                 access_s;
    logic                 ready_r;
    logic [DataWidth-1:0] rdata_r;

    assign offset_s  = bus.addr - Base;
    assign hit_s     = (bus.addr >= Base) && ((offset_s >> ByteShift) < AddrWidth'(SizeWords));
    // A request is taken only while no acknowledge is outstanding, so a held
    // request is never executed twice.
    assign access_s  = bus.valid & ~ready_r;
    assign wr_en     = access_s & bus.write & hit_s;
    assign word_addr = offset_s[ByteShift +: WordAddrW];
    assign wdata     = bus.data_ctp;

    // Acknowledge and read-data capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b0;
            rdata_r <= '0;
        end else begin
            ready_r <= access_s;
            if (access_s) begin
                rdata_r <= (hit_s && !bus.write) ? rdata : '0;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.ready    = ready_r;
    assign bus.data_ptc = rdata_r;
endmodule

// File: rtl/gpio_irq_ctrl.sv
// Edge-triggered interrupt controller for a GPIO bank.
// Ports: clk, rst (sync active-high), pins_in (raw pin levels),
//        bus_interface (arilla peripheral port), irq (registered level irq).
// Window: groups ENABLE, RISE, FALL, PENDING (write-1-to-clear), STATUS,
// each W words; unused words read 0.
module gpio_irq_ctrl
    import gpio_pkg::*;
#(
    parameter logic [31:0] BaseAddress = 32'h0000_0000,
    parameter int          NumIO       = 32,
    parameter int          SyncStages  = 2
)(
    input  logic             clk,
    input  logic             rst,
    input  logic [NumIO-1:0] pins_in,
    arilla_bus_if.peripheral bus_interface,
    output logic             irq
);
    localparam int DataWidth = $bits(bus_interface.data_ctp);
    localparam int AddrWidth = $bits(bus_interface.addr);
    localparam int W         = words_for(NumIO, DataWidth);
    localparam int PadW      = W * DataWidth;
    localparam int SizeWords = 2 ** $clog2(GROUP_COUNT * W);
    localparam int WordAddrW = $clog2(SizeWords);
    localparam logic [PadW-1:0] LowWordMask = PadW'({DataWidth{1'b1}});

    logic                 wr_en_s;
    logic [WordAddrW-1:0] word_addr_s;
    logic [DataWidth-1:0] wdata_s;
    logic [DataWidth-1:0] rdata_s;
    logic [NumIO-1:0]     level_s, rise_s, fall_s;
    logic                 armed_s;

    logic [NumIO-1:0] enable_r, rise_en_r, fall_en_r, pending_r;
    logic [NumIO-1:0] enable_next_s, rise_en_next_s, fall_en_next_s, pending_next_s;
    logic [NumIO-1:0] clear_mask_s, pend_set_s;
    logic [PadW-1:0]  word_mask_s, wdata_rep_s;
    int               grp_s, widx_s;
    logic             irq_r;

    periph_mem_interface #(
        .BaseAddress (BaseAddress),
        .SizeWords   (SizeWords),
        .DataWidth   (DataWidth),
        .AddrWidth   (AddrWidth)
    ) u_mem (
        .clk       (clk),
        .rst_n     (~rst),
        .bus       (bus_interface),
        .wr_en     (wr_en_s),
        .word_addr (word_addr_s),
        .wdata     (wdata_s),
        .rdata     (rdata_s)
    );

    gpio_edge_detect #(
        .NumIO      (NumIO),
        .SyncStages (SyncStages)
    ) u_edge (
        .clk     (clk),
        .rst     (rst),
        .pins_in (pins_in),
        .level   (level_s),
        .rise    (rise_s),
        .fall    (fall_s),
        .armed   (armed_s)
    );

    // Word idx of a pin vector, zero above NumIO.
    function automatic logic [DataWidth-1:0] word_of(input logic [NumIO-1:0] v, input int idx);
        return DataWidth'(PadW'(v) >> (idx * DataWidth));
    endfunction

    // Replace the masked bits of old with data; bits >= NumIO drop out.
    function automatic logic [NumIO-1:0] merge(input logic [NumIO-1:0] old,
                                               input logic [PadW-1:0]  mask,
                                               input logic [PadW-1:0]  data);
        return NumIO'((PadW'(old) & ~mask) | (data & mask));
    endfunction

    // Register decode: read mux, config write merge, pending clear mask.
    always_comb begin
        grp_s          = int'(word_addr_s) / W;
        widx_s         = int'(word_addr_s) % W;
        word_mask_s    = LowWordMask << (widx_s * DataWidth);
        wdata_rep_s    = {W{wdata_s}};
        rdata_s        = '0;
        enable_next_s  = enable_r;
        rise_en_next_s = rise_en_r;
        fall_en_next_s = fall_en_r;
        clear_mask_s   = '0;
        case (grp_s)
            int'(GRP_ENABLE): begin
                rdata_s = word_of(enable_r, widx_s);
                if (wr_en_s) begin
                    enable_next_s = merge(enable_r, word_mask_s, wdata_rep_s);
                end else begin
                    enable_next_s = enable_r;
                end
            end
            int'(GRP_RISE): begin
                rdata_s = word_of(rise_en_r, widx_s);
                if (wr_en_s) begin
                    rise_en_next_s = merge(rise_en_r, word_mask_s, wdata_rep_s);
                end else begin
                    rise_en_next_s = rise_en_r;
                end
            end
            int'(GRP_FALL): begin
                rdata_s = word_of(fall_en_r, widx_s);
                if (wr_en_s) begin
                    fall_en_next_s = merge(fall_en_r, word_mask_s, wdata_rep_s);
                end else begin
                    fall_en_next_s = fall_en_r;
                end
            end
            int'(GRP_PENDING): begin
                rdata_s = word_of(pending_r, widx_s);
                if (wr_en_s) begin
                    clear_mask_s = merge('0, word_mask_s, wdata_rep_s);
                end else begin
                    clear_mask_s = '0;
                end
            end
            int'(GRP_STATUS): begin
                rdata_s = word_of(level_s, widx_s);
            end
            default: begin
                rdata_s = '0;
            end
        endcase
    end

    assign pend_set_s = {NumIO{armed_s}} & enable_r &
                        ((rise_en_r & rise_s) | (fall_en_r & fall_s));
    // Set is ORed in after the clear so a coincident edge is never lost.
    assign pending_next_s = (pending_r & ~clear_mask_s) | pend_set_s;

    // Configuration, pending flags and interrupt output.
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_r  <= '0;
            rise_en_r <= '0;
            fall_en_r <= '0;
            pending_r <= '0;
            irq_r     <= 1'b0;
        end else begin
            enable_r  <= enable_next_s;
            rise_en_r <= rise_en_next_s;
            fall_en_r <= fall_en_next_s;
            pending_r <= pending_next_s;
            irq_r     <= |(pending_next_s & enable_r);
        end
    end

    assign irq = irq_r;
endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// Self-checking bench for gpio_irq_ctrl (NumIO=40, 32-bit bus, SyncStages=2).
module tb_gpio_irq_ctrl;
    localparam int          NumIO = 40;
    localparam logic [31:0] Base  = 32'h4000_0100;
    localparam int          GE = 0, GR = 1, GF = 2, GP = 3, GS = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [NumIO-1:0] pins;
    logic             irq;

    arilla_bus_if #(.AddrWidth(32), .DataWidth(32)) bus_if ();

    gpio_irq_ctrl #(
        .BaseAddress (Base),
        .NumIO       (NumIO),
        .SyncStages  (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pins_in       (pins),
        .bus_interface (bus_if),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int          tests_run    = 0;
    int          tests_failed = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int grp, input int word);
        return Base + 32'((grp * 2 + word) * 4);
    endfunction

    // One bus access; reads push their expectation, popped when ready comes back.
    task automatic bus_access(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                              input string tag, input logic [31:0] exp);
        bit          ok;
        logic [31:0] e;
        string       t;
        @(negedge clk);
        bus_if.valid    = 1'b1;
        bus_if.write    = wr;
        bus_if.addr     = addr;
        bus_if.data_ctp = data;
        if (!wr) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(posedge clk);
            #1;
            if (bus_if.ready) ok = 1'b1;
        end
        bus_if.valid = 1'b0;
        bus_if.write = 1'b0;
        if (!ok) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            if (!wr) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
            end
        end else if (!wr) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, bus_if.data_ptc, e);
        end
    endtask

    task automatic wr(input int grp, input int word, input logic [31:0] data);
        bus_access(1'b1, addr_of(grp, word), data, "write", 32'd0);
    endtask

    task automatic rd(input int grp, input int word, input logic [31:0] exp, input string tag);
        bus_access(1'b0, addr_of(grp, word), 32'd0, tag, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        pins            = '1;
        bus_if.valid    = 1'b0;
        bus_if.write    = 1'b0;
        bus_if.addr     = 32'd0;
        bus_if.data_ctp = 32'd0;

        // Reset with all pins high: no spurious pending, irq low.
        cycles(3);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycles(1);
            check($sformatf("post_reset_irq_%0d", i), {31'd0, irq}, 32'd0);
        end
        rd(GP, 0, 32'h0, "reset_pend_w0");
        rd(GP, 1, 32'h0, "reset_pend_w1");
        rd(GE, 0, 32'h0, "reset_enable_w0");
        rd(GS, 0, 32'hFFFF_FFFF, "status_w0_high");
        rd(GS, 1, 32'h0000_00FF, "status_w1_high");

        // Rising edge on pin 3, exact latency.
        @(negedge clk);
        pins = '0;
        cycles(5);
        wr(GE, 0, 32'h8);
        wr(GR, 0, 32'h8);
        cycles(2);
        @(posedge clk);
        #1;
        pins[3] = 1'b1;
        cycles(1);
        check("rise3_irq_c1", {31'd0, irq}, 32'd0);
        cycles(1);
        check("rise3_irq_c2", {31'd0, irq}, 32'd0);
        cycles(1);
        check("rise3_irq_c3", {31'd0, irq}, 32'd1);
        rd(GP, 0, 32'h8, "rise3_pend");
        wr(GP, 0, 32'h8);
        check("w1c3_irq", {31'd0, irq}, 32'd0);
        rd(GP, 0, 32'h0, "w1c3_pend");
        // Falling edge with only RISE enabled: nothing.
        pins[3] = 1'b0;
        cycles(5);
        rd(GP, 0, 32'h0, "fall3_ignored");
        check("fall3_irq", {31'd0, irq}, 32'd0);

        // Pin 35 falling edge (word 1 bit 3).
        wr(GE, 1, 32'h8);
        wr(GF, 1, 32'h8);
        pins[35] = 1'b1;
        cycles(5);
        rd(GP, 1, 32'h0, "rise35_ignored");
        pins[35] = 1'b0;
        cycles(5);
        rd(GP, 1, 32'h8, "fall35_pend");
        check("fall35_irq", {31'd0, irq}, 32'd1);
        wr(GP, 1, 32'h8);
        check("w1c35_irq", {31'd0, irq}, 32'd0);
        rd(GP, 1, 32'h0, "w1c35_pend");

        // w1c on the same cycle a new edge sets bit 3: set wins.
        @(posedge clk);
        #1;
        pins[3] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        wr(GP, 0, 32'h8);
        check("collide_irq", {31'd0, irq}, 32'd1);
        rd(GP, 0, 32'h8, "collide_pend");
        cycles(2);
        check("collide_irq_hold", {31'd0, irq}, 32'd1);
        wr(GP, 0, 32'h8);
        rd(GP, 0, 32'h0, "collide_clear");

        // Enable masking: pending bit 5 survives disable.
        wr(GE, 0, 32'h28);
        wr(GR, 0, 32'h28);
        pins[5] = 1'b1;
        cycles(5);
        rd(GP, 0, 32'h20, "pend5_set");
        check("pend5_irq", {31'd0, irq}, 32'd1);
        wr(GE, 0, 32'h08);
        cycles(2);
        check("mask5_irq", {31'd0, irq}, 32'd0);
        rd(GP, 0, 32'h20, "mask5_pend_kept");
        wr(GE, 0, 32'h28);
        cycles(2);
        check("unmask5_irq", {31'd0, irq}, 32'd1);
        wr(GP, 0, 32'h20);
        cycles(1);
        check("clear5_irq", {31'd0, irq}, 32'd0);

        // Bits above NumIO and unused words.
        wr(GE, 1, 32'hFFFF_FFFF);
        rd(GE, 1, 32'h0000_00FF, "enable_w1_width");
        rd(GS, 0, 32'h0000_0028, "status_w0_levels");
        rd(GS, 1, 32'h0000_0000, "status_w1_levels");
        bus_access(1'b1, Base + 32'd40, 32'hFFFF_FFFF, "write", 32'd0);
        for (int w = 10; w < 16; w++) begin
            bus_access(1'b0, Base + 32'(w * 4), 32'd0, $sformatf("unused_w%0d", w), 32'h0);
        end
        rd(GE, 0, 32'h0000_0028, "enable_w0_intact");

        // Mid-operation reset returns configuration to zero.
        wr(GE, 0, 32'h28);
        pins[5] = 1'b0;
        cycles(1);
        pins[5] = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycles(6);
        rd(GE, 0, 32'h0, "midrst_enable_w0");
        rd(GE, 1, 32'h0, "midrst_enable_w1");
        rd(GP, 0, 32'h0, "midrst_pend_w0");
        check("midrst_irq_after", {31'd0, irq}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
